// File: rtl/radar_pkg.sv
// Definitions shared by both ends of the radar pulse/echo link: the 2-bit state
// encoding and the default timing limits, so the tracking unit and the emulator agree.
package radar_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_DELAY = 2'd2,
    ST_ECHO  = 2'd3
  } emu_state_t;

  // The tracking unit reports its own FSM on the same 2-bit encoding.
  localparam logic [1:0] TRK_IDLE   = 2'd0;
  localparam logic [1:0] TRK_EMIT   = 2'd1;
  localparam logic [1:0] TRK_LISTEN = 2'd2;
  localparam logic [1:0] TRK_ASSESS = 2'd3;

  localparam int unsigned DEF_MIN_PULSE  = 300;
  localparam int unsigned DEF_MAX_DELAY  = 2000;
  localparam int unsigned DEF_ECHO_LEN   = 10;
  localparam int unsigned DEF_INIT_RANGE = 1500;

endpackage

// File: rtl/range_to_delay.sv
// Converts a simulated target range into a round-trip delay of floor(2*r/3) cycles,
// never less than one cycle, and flags delays beyond the listen window.
module range_to_delay
  import radar_pkg::*;
#(
  parameter int unsigned MAX_DELAY = DEF_MAX_DELAY
) (
  input  logic [31:0] range,
  output logic [31:0] delay,
  output logic        over
);

  logic [33:0] doubled;
  logic [33:0] quotient;
  logic [33:0] clamped;

  // 2*r needs 33 bits; the extra bit keeps the divider input unsigned and overflow-free.
  assign doubled  = {1'b0, range, 1'b0};
  assign quotient = doubled / 34'd3;
  assign clamped  = (quotient == 34'd0) ? 34'd1 : quotient;
  assign over     = clamped > 34'(MAX_DELAY);
  assign delay    = clamped[31:0];

endmodule

// File: rtl/radar_target_emulator.sv
// Responder end of the radar link: validates trigger pulses, answers with a delayed
// fixed-length echo, and closes the simulated target range after every echo.
module radar_target_emulator
  import radar_pkg::*;
#(
  parameter int unsigned MIN_PULSE  = DEF_MIN_PULSE,
  parameter int unsigned MAX_DELAY  = DEF_MAX_DELAY,
  parameter int unsigned ECHO_LEN   = DEF_ECHO_LEN,
  parameter int unsigned INIT_RANGE = DEF_INIT_RANGE
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        radar_pulse_trigger,
  input  logic        load_range,
  input  logic [31:0] range_in,
  input  logic [31:0] closing_speed,
  output logic        radar_echo,
  output logic [31:0] current_range,
  output logic [15:0] echo_count,
  output logic [15:0] missed_count,
  output logic        out_of_range,
  output logic        short_pulse,
  output logic [1:0]  emu_state
);

  emu_state_t  state;
  logic        trig_hist;
  logic [31:0] width_cnt;
  logic [31:0] delay_cnt;
  logic [31:0] echo_cnt;

  logic [31:0] delay_val;
  logic        delay_over;
  logic        rise;
  logic        echo_done;
  logic [31:0] closed_range;

  range_to_delay #(
    .MAX_DELAY(MAX_DELAY)
  ) u_range_to_delay (
    .range(current_range),
    .delay(delay_val),
    .over (delay_over)
  );

  assign rise         = radar_pulse_trigger & ~trig_hist;
  assign echo_done    = (state == ST_ECHO) && (echo_cnt <= 32'd1);
  assign closed_range = (closing_speed >= current_range) ? 32'd0
                                                         : current_range - closing_speed;
  assign emu_state    = state;

  // NOTE: reset is sampled on the clock edge, so it is tested inside the clocked
  // block rather than listed in the sensitivity list.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= ST_IDLE;
      trig_hist     <= 1'b0;
      width_cnt     <= '0;
      delay_cnt     <= '0;
      echo_cnt      <= '0;
      radar_echo    <= 1'b0;
      current_range <= INIT_RANGE;
      echo_count    <= '0;
      missed_count  <= '0;
      out_of_range  <= 1'b0;
      short_pulse   <= 1'b0;
    end else begin
      // NOTE: every register here uses <= so all updates see pre-edge values.
      trig_hist    <= radar_pulse_trigger;
      out_of_range <= 1'b0;
      short_pulse  <= 1'b0;

      if (rise && (state == ST_DELAY || state == ST_ECHO))
        missed_count <= missed_count + 16'd1;

      // An explicit load overrides the closing step taken on the same edge.
      if (load_range)
        current_range <= range_in;
      else if (echo_done)
        current_range <= closed_range;

      case (state)
        ST_IDLE: begin
          if (rise) begin
            width_cnt <= 32'd1;
            state     <= ST_PULSE;
          end
        end

        ST_PULSE: begin
          if (radar_pulse_trigger) begin
            if (width_cnt != '1)
              width_cnt <= width_cnt + 32'd1;
          end else if (width_cnt < MIN_PULSE) begin
            short_pulse <= 1'b1;
            state       <= ST_IDLE;
          end else if (delay_over) begin
            out_of_range <= 1'b1;
            state        <= ST_IDLE;
          end else begin
            delay_cnt <= delay_val;
            state     <= ST_DELAY;
          end
        end

        ST_DELAY: begin
          if (delay_cnt <= 32'd1) begin
            radar_echo <= 1'b1;
            echo_cnt   <= ECHO_LEN;
            state      <= ST_ECHO;
          end else begin
            delay_cnt <= delay_cnt - 32'd1;
          end
        end

        ST_ECHO: begin
          echo_cnt <= echo_cnt - 32'd1;
          if (echo_done) begin
            radar_echo <= 1'b0;
            echo_count <= echo_count + 16'd1;
            state      <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_radar_target_emulator.sv
// Directed bench for radar_target_emulator: a table of single-pulse transactions
// plus hand-written sequences for missed pulses, load priority and mid-delay reset.
module tb_radar_target_emulator;

  localparam int MAX_DELAY = 2000;
  localparam int ECHO_LEN  = 10;

  logic        clk;
  logic        rst;
  logic        trigger;
  logic        load_range;
  logic [31:0] range_in;
  logic [31:0] closing_speed;
  logic        radar_echo;
  logic [31:0] current_range;
  logic [15:0] echo_count;
  logic [15:0] missed_count;
  logic        out_of_range;
  logic        short_pulse;
  logic [1:0]  emu_state;

  radar_target_emulator dut (
    .CLK                (clk),
    .RST                (rst),
    .radar_pulse_trigger(trigger),
    .load_range         (load_range),
    .range_in           (range_in),
    .closing_speed      (closing_speed),
    .radar_echo         (radar_echo),
    .current_range      (current_range),
    .echo_count         (echo_count),
    .missed_count       (missed_count),
    .out_of_range       (out_of_range),
    .short_pulse        (short_pulse),
    .emu_state          (emu_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Number of rising clock edges so far; read at negedges to timestamp outputs.
  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int checks = 0;
  int errors = 0;
  int exp_echo = 0;
  int exp_missed = 0;

  typedef struct {
    bit do_load;
    int range;
    int speed;
    int width;
    int exp_delay;   // 0 means no echo expected
    int exp_short;
    int exp_oor;
    int exp_range;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_edge(input int e);
    while (edge_n < e) @(negedge clk);
  endtask

  task automatic do_load(input int r);
    load_range = 1'b1;
    range_in   = r;
    @(negedge clk);
    load_range = 1'b0;
  endtask

  // Drives a pulse sampled high on `width` edges; returns T0, the first low-sampled edge.
  task automatic pulse(input int width, output int t0);
    trigger = 1'b1;
    repeat (width) @(negedge clk);
    trigger = 1'b0;
    t0 = edge_n + 1;
  endtask

  task automatic observe(input int budget, output int rise_e, output int high_n,
                         output int short_n, output int short_e,
                         output int oor_n, output int oor_e, output bit timed_out);
    rise_e = -1; high_n = 0; short_n = 0; short_e = -1; oor_n = 0; oor_e = -1;
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (radar_echo)   begin if (rise_e < 0)  rise_e  = edge_n; high_n++;  end
      if (short_pulse)  begin if (short_e < 0) short_e = edge_n; short_n++; end
      if (out_of_range) begin if (oor_e < 0)   oor_e   = edge_n; oor_n++;   end
      if (emu_state == 2'd0 && !radar_echo && i >= 2) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " echo"},    radar_echo, 0);
    check({tag, " range"},   current_range, 1500);
    check({tag, " echoes"},  echo_count, 0);
    check({tag, " missed"},  missed_count, 0);
    check({tag, " oor"},     out_of_range, 0);
    check({tag, " short"},   short_pulse, 0);
    check({tag, " state"},   emu_state, 0);
  endtask

  initial begin
    int t0, t1, rise_e, high_n, short_n, short_e, oor_n, oor_e, extra;
    bit timed_out;

    //              load range  speed width delay short oor  range_after
    vecs[0]  = '{1'b0, 1500,    0, 300, 1000, 0, 0, 1500};
    vecs[1]  = '{1'b0, 1500,   30, 300, 1000, 0, 0, 1470};
    vecs[2]  = '{1'b0, 1470,   30, 300,  980, 0, 0, 1440};
    vecs[3]  = '{1'b1, 3003,   30, 300,    0, 0, 1, 3003};
    vecs[4]  = '{1'b1, 1500,    0, 100,    0, 1, 0, 1500};
    vecs[5]  = '{1'b0, 1500,    0, 299,    0, 1, 0, 1500};
    vecs[6]  = '{1'b1, 3000,    0, 300, 2000, 0, 0, 3000};
    vecs[7]  = '{1'b1, 3002,    0, 300,    0, 0, 1, 3002};
    vecs[8]  = '{1'b1,    1,    5, 300,    1, 0, 0,    0};
    vecs[9]  = '{1'b0,    0,    0, 400,    1, 0, 0,    0};
    vecs[10] = '{1'b1,    2,    0, 301,    1, 0, 0,    2};
    vecs[11] = '{1'b1, 1500, 1500, 300, 1000, 0, 0,    0};

    rst = 1'b1; trigger = 1'b0; load_range = 1'b0; range_in = '0; closing_speed = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_state("reset");

    for (int i = 0; i < 12; i++) begin
      repeat (2) @(negedge clk);
      closing_speed = vecs[i].speed;
      if (vecs[i].do_load) do_load(vecs[i].range);
      pulse(vecs[i].width, t0);
      observe(MAX_DELAY + ECHO_LEN + 20, rise_e, high_n, short_n, short_e, oor_n, oor_e,
              timed_out);
      check($sformatf("v%0d back to idle", i), timed_out, 0);
      if (vecs[i].exp_delay > 0) begin
        check($sformatf("v%0d echo delay", i), rise_e - t0, vecs[i].exp_delay);
        check($sformatf("v%0d echo length", i), high_n, ECHO_LEN);
        exp_echo++;
      end else begin
        check($sformatf("v%0d no echo", i), high_n, 0);
      end
      check($sformatf("v%0d short cycles", i), short_n, vecs[i].exp_short);
      check($sformatf("v%0d oor cycles", i), oor_n, vecs[i].exp_oor);
      if (vecs[i].exp_short != 0) check($sformatf("v%0d short edge", i), short_e, t0);
      if (vecs[i].exp_oor != 0)   check($sformatf("v%0d oor edge", i), oor_e, t0);
      check($sformatf("v%0d echo_count", i), echo_count, exp_echo);
      check($sformatf("v%0d range", i), current_range, vecs[i].exp_range);
      check($sformatf("v%0d missed", i), missed_count, exp_missed);
    end

    // Second pulse 200 cycles into DELAY: counted as missed, never answered.
    repeat (2) @(negedge clk);
    closing_speed = 0;
    do_load(1500);
    pulse(300, t0);
    wait_edge(t0 + 199);
    pulse(300, t1);
    observe(MAX_DELAY, rise_e, high_n, short_n, short_e, oor_n, oor_e, timed_out);
    exp_echo++; exp_missed++;
    check("miss idle", timed_out, 0);
    check("miss echo delay", rise_e - t0, 1000);
    check("miss echo length", high_n, ECHO_LEN);
    check("miss count", missed_count, exp_missed);
    extra = 0;
    repeat (1200) begin @(negedge clk); if (radar_echo) extra++; end
    check("miss no second echo", extra, 0);
    check("miss echo_count", echo_count, exp_echo);

    // Load during DELAY leaves the latched delay alone; load on the closing edge wins.
    closing_speed = 30;
    do_load(1500);
    pulse(300, t0);
    wait_edge(t0 + 99);
    do_load(600);
    wait_edge(t0 + 999);
    check("load pre-echo low", radar_echo, 0);
    check("load mid-delay range", current_range, 600);
    @(negedge clk);
    check("load echo rises at 1000", radar_echo, 1);
    wait_edge(t0 + 1009);
    do_load(777);
    exp_echo++;
    check("load echo falls", radar_echo, 0);
    check("load wins over closing", current_range, 777);
    check("load echo_count", echo_count, exp_echo);
    check("load idle", emu_state, 0);

    // Rising edge sampled on the edge that returns to IDLE is missed, next one accepted.
    closing_speed = 0;
    do_load(3);
    pulse(300, t0);
    wait_edge(t0 + 11);
    trigger = 1'b1;
    @(negedge clk);
    exp_echo++; exp_missed++;
    check("ret echo falls", radar_echo, 0);
    check("ret missed", missed_count, exp_missed);
    repeat (5) @(negedge clk);
    check("ret stays idle", emu_state, 0);
    trigger = 1'b0;
    @(negedge clk);
    pulse(300, t0);
    observe(100, rise_e, high_n, short_n, short_e, oor_n, oor_e, timed_out);
    exp_echo++;
    check("ret next delay", rise_e - t0, 2);
    check("ret echo_count", echo_count, exp_echo);

    // Reset 500 cycles into DELAY cancels the echo and restores every output.
    do_load(1800);
    pulse(300, t0);
    wait_edge(t0 + 499);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("midrst");
    extra = 0;
    repeat (1000) begin @(negedge clk); if (radar_echo) extra++; end
    check("midrst no echo", extra, 0);
    pulse(300, t0);
    observe(MAX_DELAY + ECHO_LEN + 20, rise_e, high_n, short_n, short_e, oor_n, oor_e,
            timed_out);
    check("midrst idle", timed_out, 0);
    check("midrst echo delay", rise_e - t0, 1000);
    check("midrst echo length", high_n, ECHO_LEN);
    check("midrst echo_count", echo_count, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
